// File: rtl/had_regacc_ctrl.sv
// Debug register-access sequencer: turns IR/DR update pulses from the serial
// debug stage into single register-bus read/write requests with a timeout.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no transaction; waiting for an IR update
// ST_WAIT_DR | write IR latched; waiting for the data frame
// ST_WR_REQ  | register-bus write request outstanding
// ST_RD_REQ  | register-bus read request outstanding
module had_regacc_ctrl #(
    parameter logic [7:0] TIMEOUT_CYC = 8'd255
) (
    input  logic        forever_cpuclk_nogated,
    input  logic        hadrst_b,
    input  logic        ir_upd,
    input  logic        dr_upd,
    input  logic [31:0] sdata,
    output logic [31:0] rdata_out,
    output logic        rdata_vld,
    output logic        regacc_req,
    output logic        regacc_wr,
    output logic [6:0]  regacc_addr,
    output logic [31:0] regacc_wdata,
    input  logic        regacc_ack,
    input  logic [31:0] regacc_rdata,
    output logic        busy,
    output logic        err_sticky
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_DR = 2'd1;
    localparam logic [1:0] ST_WR_REQ  = 2'd2;
    localparam logic [1:0] ST_RD_REQ  = 2'd3;

    localparam logic [7:0] IR_CLR_ERR = 8'h7F;

    logic [1:0] state;
    logic [7:0] ir;
    logic [7:0] req_cnt;
    logic       req_timeout;

    assign regacc_req  = (state == ST_WR_REQ) || (state == ST_RD_REQ);
    assign regacc_wr   = (state == ST_WR_REQ);
    assign regacc_addr = ir[6:0];
    assign busy        = (state != ST_IDLE);
    assign req_timeout = (req_cnt == TIMEOUT_CYC);

    always_ff @(posedge forever_cpuclk_nogated) begin
        if (!hadrst_b) begin
            state        <= ST_IDLE;
            ir           <= 8'h00;
            req_cnt      <= 8'h00;
            regacc_wdata <= 32'h0;
            rdata_out    <= 32'h0;
            rdata_vld    <= 1'b0;
            err_sticky   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_WAIT_DR: begin
                    if (ir_upd) begin
                        ir        <= sdata[7:0];
                        rdata_vld <= 1'b0;
                        if (sdata[7]) begin
                            state   <= ST_RD_REQ;
                            req_cnt <= 8'h00;
                        end else if (sdata[7:0] == IR_CLR_ERR) begin
                            err_sticky <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            state <= ST_WAIT_DR;
                        end
                    end else if (dr_upd && (state == ST_WAIT_DR)) begin
                        regacc_wdata <= sdata;
                        state        <= ST_WR_REQ;
                        req_cnt      <= 8'h00;
                    end
                end
                ST_WR_REQ, ST_RD_REQ: begin
                    // Overrun: the frame is dropped but the bus transaction carries on.
                    if (ir_upd || dr_upd) begin
                        err_sticky <= 1'b1;
                    end
                    if (regacc_ack) begin
                        state <= ST_IDLE;
                        if (state == ST_RD_REQ) begin
                            rdata_out <= regacc_rdata;
                            rdata_vld <= 1'b1;
                        end
                    end else if (req_timeout) begin
                        state      <= ST_IDLE;
                        err_sticky <= 1'b1;
                        if (state == ST_RD_REQ) begin
                            rdata_out <= 32'h0;
                            rdata_vld <= 1'b1;
                        end
                    end else begin
                        req_cnt <= req_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_had_regacc_ctrl.sv
// Bench for had_regacc_ctrl: directed vector table, timeout/priority sequences,
// then randomized traffic compared against a transaction-level reference model.
module tb_had_regacc_ctrl;

    localparam logic [7:0] TO = 8'd255;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        ir_upd = 1'b0;
    logic        dr_upd = 1'b0;
    logic [31:0] sdata = 32'h0;
    logic        ack = 1'b0;
    logic [31:0] ack_rdata = 32'h0;

    logic [31:0] rdata_out;
    logic        rdata_vld;
    logic        regacc_req;
    logic        regacc_wr;
    logic [6:0]  regacc_addr;
    logic [31:0] regacc_wdata;
    logic        busy;
    logic        err_sticky;

    int checks = 0;
    int errors = 0;

    had_regacc_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .forever_cpuclk_nogated(clk),
        .hadrst_b    (rst_b),
        .ir_upd      (ir_upd),
        .dr_upd      (dr_upd),
        .sdata       (sdata),
        .rdata_out   (rdata_out),
        .rdata_vld   (rdata_vld),
        .regacc_req  (regacc_req),
        .regacc_wr   (regacc_wr),
        .regacc_addr (regacc_addr),
        .regacc_wdata(regacc_wdata),
        .regacc_ack  (ack),
        .regacc_rdata(ack_rdata),
        .busy        (busy),
        .err_sticky  (err_sticky)
    );

    always #5 clk = ~clk;

    // Reference model: one optional outstanding transaction plus an "armed for DR" flag.
    logic        m_txn, m_rd, m_armed, m_err, m_vld;
    logic [6:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;
    int          m_age;

    task automatic model_step();
        if (!rst_b) begin
            m_txn = 0; m_rd = 0; m_armed = 0; m_err = 0; m_vld = 0;
            m_addr = 0; m_wdata = 0; m_rdata = 0; m_age = 0;
        end else if (m_txn) begin
            if (ir_upd || dr_upd) m_err = 1;
            if (ack) begin
                m_txn = 0;
                if (m_rd) begin m_rdata = ack_rdata; m_vld = 1; end
            end else if (m_age == int'(TO)) begin
                m_txn = 0;
                m_err = 1;
                if (m_rd) begin m_rdata = 0; m_vld = 1; end
            end else begin
                m_age++;
            end
        end else if (ir_upd) begin
            m_vld = 0;
            m_addr = sdata[6:0];
            m_armed = 0;
            if (sdata[7]) begin
                m_txn = 1; m_rd = 1; m_age = 0;
            end else if (sdata[7:0] == 8'h7F) begin
                m_err = 0;
            end else begin
                m_armed = 1;
            end
        end else if (dr_upd && m_armed) begin
            m_wdata = sdata;
            m_txn = 1; m_rd = 0; m_age = 0; m_armed = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic i, input logic d, input logic a,
                         input logic [31:0] sd, input logic [31:0] ard);
        rst_b = r; ir_upd = i; dr_upd = d; ack = a; sdata = sd; ack_rdata = ard;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    typedef struct {
        logic        r, i, d, a;
        logic [31:0] sd, ard;
        logic        e_req, e_wr;
        logic [6:0]  e_addr;
        logic [31:0] e_wdata;
        logic        e_busy, e_err, e_vld;
        logic [31:0] e_rdata;
        logic        chk_all;
    } vec_t;

    function automatic vec_t v(logic r, logic i, logic d, logic a, logic [31:0] sd,
                               logic [31:0] ard, logic er, logic ew, logic [6:0] ea,
                               logic [31:0] ewd, logic eb, logic ee, logic evl,
                               logic [31:0] erd, logic ca);
        vec_t x;
        x.r = r; x.i = i; x.d = d; x.a = a; x.sd = sd; x.ard = ard;
        x.e_req = er; x.e_wr = ew; x.e_addr = ea; x.e_wdata = ewd;
        x.e_busy = eb; x.e_err = ee; x.e_vld = evl; x.e_rdata = erd; x.chk_all = ca;
        return x;
    endfunction

    vec_t vt[20];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        //             r i d a sdata          ack_rdata     req wr addr   wdata          bsy err vld rdata        all
        vt[0]  = v(0,0,0,0,32'h0,         32'h0,        0,0,7'h00,32'h0,         0,0,0,32'h0,         1);
        vt[1]  = v(1,1,0,0,32'h05,        32'h0,        0,0,7'h00,32'h0,         1,0,0,32'h0,         0);
        vt[2]  = v(1,0,1,0,32'hA5A5_0001, 32'h0,        1,1,7'h05,32'hA5A5_0001, 1,0,0,32'h0,         0);
        vt[3]  = v(1,0,0,0,32'h0,         32'h0,        1,1,7'h05,32'hA5A5_0001, 1,0,0,32'h0,         0);
        vt[4]  = v(1,0,0,0,32'h0,         32'h0,        1,1,7'h05,32'hA5A5_0001, 1,0,0,32'h0,         0);
        vt[5]  = v(1,0,0,1,32'h0,         32'h0,        0,0,7'h00,32'h0,         0,0,0,32'h0,         0);
        vt[6]  = v(1,1,0,0,32'h01,        32'h0,        0,0,7'h00,32'h0,         1,0,0,32'h0,         0);
        vt[7]  = v(1,1,1,0,32'h86,        32'h0,        1,0,7'h06,32'h0,         1,0,0,32'h0,         0);
        vt[8]  = v(1,0,0,1,32'h0,         32'hDEAD_BEEF,0,0,7'h00,32'h0,         0,0,1,32'hDEAD_BEEF, 0);
        vt[9]  = v(1,1,0,0,32'h83,        32'h0,        1,0,7'h03,32'h0,         1,0,0,32'hDEAD_BEEF, 0);
        vt[10] = v(1,0,1,0,32'hFFFF_FFFF, 32'h0,        1,0,7'h03,32'h0,         1,1,0,32'hDEAD_BEEF, 0);
        vt[11] = v(1,0,0,1,32'h0,         32'h1234_5678,0,0,7'h00,32'h0,         0,1,1,32'h1234_5678, 0);
        vt[12] = v(1,0,0,1,32'h0,         32'h0,        0,0,7'h00,32'h0,         0,1,1,32'h1234_5678, 0);
        vt[13] = v(1,1,0,0,32'h7F,        32'h0,        0,0,7'h00,32'h0,         0,0,0,32'h1234_5678, 0);
        vt[14] = v(1,0,1,0,32'h55,        32'h0,        0,0,7'h00,32'h0,         0,0,0,32'h1234_5678, 0);
        vt[15] = v(1,1,0,0,32'h10,        32'h0,        0,0,7'h00,32'h0,         1,0,0,32'h1234_5678, 0);
        vt[16] = v(1,0,1,0,32'h0000_CAFE, 32'h0,        1,1,7'h10,32'h0000_CAFE, 1,0,0,32'h1234_5678, 0);
        vt[17] = v(1,1,0,0,32'h22,        32'h0,        1,1,7'h10,32'h0000_CAFE, 1,1,0,32'h1234_5678, 0);
        vt[18] = v(0,0,0,0,32'h0,         32'h0,        0,0,7'h00,32'h0,         0,0,0,32'h0,         1);
        vt[19] = v(1,0,0,1,32'h0,         32'hFFFF_FFFF,0,0,7'h00,32'h0,         0,0,0,32'h0,         1);

        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            drive(vt[k].r, vt[k].i, vt[k].d, vt[k].a, vt[k].sd, vt[k].ard);
            tick();
            chk($sformatf("vec%0d_req", k), {31'b0, regacc_req}, {31'b0, vt[k].e_req});
            chk($sformatf("vec%0d_busy", k), {31'b0, busy}, {31'b0, vt[k].e_busy});
            chk($sformatf("vec%0d_err", k), {31'b0, err_sticky}, {31'b0, vt[k].e_err});
            chk($sformatf("vec%0d_vld", k), {31'b0, rdata_vld}, {31'b0, vt[k].e_vld});
            chk($sformatf("vec%0d_rdata", k), rdata_out, vt[k].e_rdata);
            if (vt[k].e_req || vt[k].chk_all) begin
                chk($sformatf("vec%0d_wr", k), {31'b0, regacc_wr}, {31'b0, vt[k].e_wr});
                chk($sformatf("vec%0d_addr", k), {25'b0, regacc_addr}, {25'b0, vt[k].e_addr});
            end
            if ((vt[k].e_req && vt[k].e_wr) || vt[k].chk_all)
                chk($sformatf("vec%0d_wdata", k), regacc_wdata, vt[k].e_wdata);
        end

        // Read that never gets an ack: request must stay up exactly TO+1 cycles.
        drive(1,1,0,0,32'h81,32'h0);
        tick();
        drive(1,0,0,0,32'h0,32'h0);
        cnt = 0;
        while (regacc_req && cnt < 300) begin
            cnt++;
            tick();
        end
        chk("to_req_cycles", cnt, 256);
        chk("to_rdata", rdata_out, 32'h0);
        chk("to_vld", {31'b0, rdata_vld}, 32'h1);
        chk("to_err", {31'b0, err_sticky}, 32'h1);
        chk("to_busy", {31'b0, busy}, 32'h0);

        drive(1,1,0,0,32'h7F,32'h0);
        tick();
        chk("clr_err", {31'b0, err_sticky}, 32'h0);
        drive(1,0,0,0,32'h0,32'h0);
        for (int k = 0; k < 3; k++) begin
            chk("clr_noreq", {31'b0, regacc_req}, 32'h0);
            tick();
        end

        // Ack arriving in the same cycle the timeout would fire must win.
        drive(1,1,0,0,32'h82,32'h0);
        tick();
        drive(1,0,0,0,32'h0,32'h0);
        for (int k = 1; k < 256; k++) tick();
        chk("prio_req_before", {31'b0, regacc_req}, 32'h1);
        chk("prio_addr", {25'b0, regacc_addr}, 32'h02);
        drive(1,0,0,1,32'h0,32'h0BAD_F00D);
        tick();
        drive(1,0,0,0,32'h0,32'h0);
        chk("prio_req_after", {31'b0, regacc_req}, 32'h0);
        chk("prio_err", {31'b0, err_sticky}, 32'h0);
        chk("prio_vld", {31'b0, rdata_vld}, 32'h1);
        chk("prio_rdata", rdata_out, 32'h0BAD_F00D);

        // Randomized traffic against the reference model.
        drive(0,0,0,0,32'h0,32'h0);
        tick();
        for (int n = 0; n < 5000; n++) begin
            logic [31:0] sd;
            int ack_div;
            sd = $urandom;
            case ($urandom_range(0,3))
                0: ;
                1: sd[7:0] = 8'h7F;
                2: sd[7] = 1'b1;
                default: sd[7] = 1'b0;
            endcase
            ack_div = (n < 2500) ? 3 : 300;
            drive(($urandom_range(0,399) != 0),
                  ($urandom_range(0,9) == 0),
                  ($urandom_range(0,4) == 0),
                  ($urandom_range(0,ack_div) == 0),
                  sd, $urandom);
            tick();
            chk("rnd_req", {31'b0, regacc_req}, {31'b0, m_txn});
            chk("rnd_busy", {31'b0, busy}, {31'b0, m_txn || m_armed});
            chk("rnd_err", {31'b0, err_sticky}, {31'b0, m_err});
            chk("rnd_vld", {31'b0, rdata_vld}, {31'b0, m_vld});
            chk("rnd_rdata", rdata_out, m_rdata);
            if (m_txn) begin
                chk("rnd_wr", {31'b0, regacc_wr}, {31'b0, !m_rd});
                chk("rnd_addr", {25'b0, regacc_addr}, {25'b0, m_addr});
                if (!m_rd) chk("rnd_wdata", regacc_wdata, m_wdata);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
